// File: rtl/riscv_hpm_pkg.sv
// Shared constants and types for the hardware performance counter bank.
// Defaults here are the bank's parameter defaults.
package riscv_hpm_pkg;

    localparam int unsigned HPM_NUM_COUNTERS  = 4;
    localparam int unsigned HPM_COUNTER_WIDTH = 64;
    localparam int unsigned HPM_STEP_WIDTH    = 2;

    typedef logic [4:0] hpm_idx_t;

endpackage

// File: rtl/riscv_hpm_counter_slice.sv
// One performance counter: CSR write merge, gated increment, sticky overflow.
// A CSR write in the same cycle as an increment wins and never flags overflow.
module riscv_hpm_counter_slice
    import riscv_hpm_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = HPM_COUNTER_WIDTH,
    parameter int unsigned STEP_WIDTH    = HPM_STEP_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     inc_valid,
    input  logic [STEP_WIDTH-1:0]    inc_amount,
    input  logic                     inhibit,
    input  logic                     wr_en,
    input  logic                     wr_hi,
    input  logic [31:0]              wr_data,
    input  logic                     ovf_clr,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     ovf_flag
);

    logic [COUNTER_WIDTH-1:0] count_d, count_q;
    logic                     ovf_d, ovf_q;
    logic [63:0]              wr_merge;
    logic [COUNTER_WIDTH:0]   sum;
    logic                     inc_fire;

    always_comb begin
        wr_merge = 64'(count_q);
        if (wr_hi) wr_merge[63:32] = wr_data;
        else       wr_merge[31:0]  = wr_data;

        sum = {1'b0, count_q}
            + {{(COUNTER_WIDTH + 1 - STEP_WIDTH){1'b0}}, inc_amount};
        inc_fire = inc_valid && !inhibit && (inc_amount != '0);

        count_d = count_q;
        ovf_d   = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;

        // Set after clear so a coincident carry keeps the flag.
        if (wr_en) begin
            count_d = wr_merge[COUNTER_WIDTH-1:0];
        end else if (inc_fire) begin
            count_d = sum[COUNTER_WIDTH-1:0];
            if (sum[COUNTER_WIDTH]) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign ovf_flag = ovf_q;

endmodule

// File: rtl/riscv_hpm_counter_bank.sv
// Bank of HPM counters with CSR read/write port, overflow flags and irq.
// Reads return the pre-update value one cycle after rd_en.
module riscv_hpm_counter_bank
    import riscv_hpm_pkg::*;
#(
    parameter int unsigned NUM_COUNTERS  = HPM_NUM_COUNTERS,
    parameter int unsigned COUNTER_WIDTH = HPM_COUNTER_WIDTH,
    parameter int unsigned STEP_WIDTH    = HPM_STEP_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_COUNTERS-1:0]                 inc_valid,
    input  logic [NUM_COUNTERS-1:0][STEP_WIDTH-1:0] inc_amount,
    input  logic [NUM_COUNTERS-1:0]                 inhibit,
    input  logic                                    wr_en,
    input  logic [4:0]                              wr_idx,
    input  logic                                    wr_hi,
    input  logic [31:0]                             wr_data,
    input  logic                                    rd_en,
    input  logic [4:0]                              rd_idx,
    input  logic                                    rd_hi,
    output logic                                    rd_valid,
    output logic [31:0]                             rd_data,
    input  logic [NUM_COUNTERS-1:0]                 ovf_irq_en,
    input  logic [NUM_COUNTERS-1:0]                 ovf_clr,
    output logic [NUM_COUNTERS-1:0]                 ovf_flag,
    output logic                                    irq
);

    logic [COUNTER_WIDTH-1:0] count [NUM_COUNTERS];

    logic        rd_valid_d, rd_valid_q;
    logic [31:0] rd_data_d, rd_data_q;
    logic        irq_d, irq_q;
    logic [63:0] rd_sel;
    logic [31:0] rd_word;

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_slice
        riscv_hpm_counter_slice #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .STEP_WIDTH    (STEP_WIDTH)
        ) u_slice (
            .clk        (clk),
            .reset_n    (reset_n),
            .inc_valid  (inc_valid[i]),
            .inc_amount (inc_amount[i]),
            .inhibit    (inhibit[i]),
            .wr_en      (wr_en && (wr_idx == 5'(i))),
            .wr_hi      (wr_hi),
            .wr_data    (wr_data),
            .ovf_clr    (ovf_clr[i]),
            .count      (count[i]),
            .ovf_flag   (ovf_flag[i])
        );
    end

    // Out-of-range indices and the missing upper half of 32-bit counters read 0.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (rd_idx == 5'(i)) rd_sel = 64'(count[i]);
        end
        rd_word    = rd_hi ? rd_sel[63:32] : rd_sel[31:0];
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_word : rd_data_q;
        irq_d      = |(ovf_flag & ovf_irq_en);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            irq_q      <= irq_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_riscv_hpm_counter_bank.sv
// Self-checking bench for riscv_hpm_counter_bank: directed scenarios plus
// randomized traffic against a behavioural model of the counter bank.
module tb_riscv_hpm_counter_bank;

    localparam int N  = 4;
    localparam int SW = 2;

    logic                  clk;
    logic                  reset_n;
    logic [N-1:0]          inc_valid;
    logic [N-1:0][SW-1:0]  inc_amount;
    logic [N-1:0]          inhibit;
    logic                  wr_en;
    logic [4:0]            wr_idx;
    logic                  wr_hi;
    logic [31:0]           wr_data;
    logic                  rd_en;
    logic [4:0]            rd_idx;
    logic                  rd_hi;
    logic                  rd_valid;
    logic [31:0]           rd_data;
    logic [N-1:0]          ovf_irq_en;
    logic [N-1:0]          ovf_clr;
    logic [N-1:0]          ovf_flag;
    logic                  irq;

    riscv_hpm_counter_bank #(
        .NUM_COUNTERS  (N),
        .COUNTER_WIDTH (64),
        .STEP_WIDTH    (SW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .inc_valid  (inc_valid),
        .inc_amount (inc_amount),
        .inhibit    (inhibit),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_hi      (wr_hi),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_hi      (rd_hi),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .ovf_irq_en (ovf_irq_en),
        .ovf_clr    (ovf_clr),
        .ovf_flag   (ovf_flag),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [63:0]  m_cnt [N];
    logic [N-1:0] m_flag;
    logic         m_irq;
    logic         m_rv;
    logic [31:0]  m_rd;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = '0;
        m_flag = '0;
        m_irq  = 1'b0;
        m_rv   = 1'b0;
        m_rd   = '0;
    endfunction

    function automatic void model_step();
        logic [64:0]  s;
        logic [N-1:0] nf;
        m_irq = |(m_flag & ovf_irq_en);
        m_rv  = rd_en;
        if (rd_en) begin
            if (rd_idx < 5'(N))
                m_rd = rd_hi ? m_cnt[rd_idx][63:32] : m_cnt[rd_idx][31:0];
            else
                m_rd = '0;
        end
        nf = m_flag & ~ovf_clr;
        for (int i = 0; i < N; i++) begin
            if (wr_en && wr_idx == 5'(i)) begin
                if (wr_hi) m_cnt[i] = {wr_data, m_cnt[i][31:0]};
                else       m_cnt[i] = {m_cnt[i][63:32], wr_data};
            end else if (inc_valid[i] && !inhibit[i]) begin
                s = {1'b0, m_cnt[i]} + 65'(inc_amount[i]);
                m_cnt[i] = s[63:0];
                if (s[64]) nf[i] = 1'b1;
            end
        end
        m_flag = nf;
    endfunction

    task automatic idle();
        inc_valid  = '0;
        inc_amount = '0;
        inhibit    = '0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_hi      = 1'b0;
        wr_data    = '0;
        rd_en      = 1'b0;
        rd_idx     = '0;
        rd_hi      = 1'b0;
        ovf_clr    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
    endtask

    task automatic wr(input int idx, input bit hi, input logic [31:0] d);
        wr_en = 1'b1; wr_idx = 5'(idx); wr_hi = hi; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input int idx, input bit hi);
        rd_en = 1'b1; rd_idx = 5'(idx); rd_hi = hi;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        ovf_irq_en = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp += 4;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        if (ovf_flag !== '0) begin n_fail++; $display("FAIL reset_ovf_flag got %b want 0", ovf_flag); end
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
        reset_n = 1'b1;
        tick();
        rd(3, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_count3_hi got v=%b d=%h want v=1 d=0", rd_valid, rd_data);
        end
    endtask

    task automatic test_overflow_irq();
        ovf_irq_en = 4'b0001;
        wr(0, 1'b0, 32'hFFFF_FFFE);
        wr(0, 1'b1, 32'hFFFF_FFFF);
        inc_valid[0] = 1'b1; inc_amount[0] = 2'd3;
        tick();
        inc_valid = '0; inc_amount = '0;
        n_cmp += 2;
        if (ovf_flag[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf_flag[0]); end
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_not_yet got %b want 0", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise got %b want 1", irq); end
        rd(0, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1) begin
            n_fail++; $display("FAIL wrap_lo got v=%b d=%h want v=1 d=1", rd_valid, rd_data);
        end
        rd(0, 1'b1);
        n_cmp++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL wrap_hi got %h want 0", rd_data); end
    endtask

    task automatic test_write_read();
        wr(2, 1'b0, 32'hDEAD_BEEF);
        wr(2, 1'b1, 32'h0000_0001);
        rd(2, 1'b0);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_lo got v=%b d=%h want v=1 d=deadbeef", rd_valid, rd_data);
        end
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_hold got v=%b d=%h want v=0 d=deadbeef", rd_valid, rd_data);
        end
        rd(2, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h1) begin
            n_fail++; $display("FAIL rd_hi got v=%b d=%h want v=1 d=1", rd_valid, rd_data);
        end
    endtask

    task automatic test_write_wins();
        inc_valid[1] = 1'b1; inc_amount[1] = 2'd2;
        wr(1, 1'b0, 32'd5);
        inc_valid = '0; inc_amount = '0;
        rd(1, 1'b0);
        n_cmp += 2;
        if (rd_data !== 32'd5) begin n_fail++; $display("FAIL write_wins got %0d want 5", rd_data); end
        if (ovf_flag[1] !== 1'b0) begin n_fail++; $display("FAIL write_wins_ovf got %b want 0", ovf_flag[1]); end
    endtask

    task automatic test_inhibit();
        wr(3, 1'b0, 32'd100);
        inhibit[3] = 1'b1; inc_valid[3] = 1'b1; inc_amount[3] = 2'd1;
        repeat (10) tick();
        inc_valid = '0;
        rd(3, 1'b0);
        n_cmp++;
        if (rd_data !== 32'd100) begin n_fail++; $display("FAIL inhibit_hold got %0d want 100", rd_data); end
        inhibit = '0; inc_valid[3] = 1'b1;
        repeat (4) tick();
        inc_valid = '0; inc_amount = '0;
        rd(3, 1'b0);
        n_cmp++;
        if (rd_data !== 32'd104) begin n_fail++; $display("FAIL inhibit_release got %0d want 104", rd_data); end
    endtask

    task automatic test_ovf_clr_race();
        ovf_clr = '1;
        tick();
        ovf_clr = '0;
        tick();
        n_cmp++;
        if (ovf_flag !== '0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL clr_all got f=%b irq=%b want 0 0", ovf_flag, irq);
        end
        ovf_irq_en = 4'b0001;
        wr(0, 1'b0, 32'hFFFF_FFFF);
        wr(0, 1'b1, 32'hFFFF_FFFF);
        inc_valid[0] = 1'b1; inc_amount[0] = 2'd1; ovf_clr[0] = 1'b1;
        tick();
        inc_valid = '0; inc_amount = '0; ovf_clr = '0;
        n_cmp++;
        if (ovf_flag[0] !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr got %b want 1", ovf_flag[0]); end
        ovf_clr[0] = 1'b1;
        tick();
        ovf_clr = '0;
        n_cmp += 2;
        if (ovf_flag[0] !== 1'b0) begin n_fail++; $display("FAIL clr got %b want 0", ovf_flag[0]); end
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_lag got %b want 1", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop got %b want 0", irq); end
    endtask

    task automatic test_reset_mid_read();
        wr(1, 1'b0, 32'h0000_1234);
        rd(1, 1'b0);
        n_cmp++;
        if (rd_data !== 32'h1234) begin n_fail++; $display("FAIL pre_rst_rd got %h want 1234", rd_data); end
        rd_en = 1'b1; rd_idx = 5'd7; rd_hi = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        reset_n = 1'b1;
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drop_rd got %b want 0", rd_valid); end
        tick();
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got %b want 0", rd_valid); end
        wr(1, 1'b0, 32'h0000_5678);
        rd(1, 1'b0);
        rd(7, 1'b1);
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            n_fail++; $display("FAIL oor_read got v=%b d=%h want v=1 d=0", rd_valid, rd_data);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int i = 0; i < N; i++) begin
                inc_valid[i]  = 1'($urandom_range(0, 1));
                inc_amount[i] = 2'($urandom_range(0, 3));
                inhibit[i]    = ($urandom_range(0, 5) == 0);
                ovf_clr[i]    = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 15) == 0) ovf_irq_en = 4'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 2))
                    0: d = $urandom;
                    1: d = 32'hFFFF_FFFF;
                    default: d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                endcase
                wr_en = 1'b1; wr_idx = 5'($urandom_range(0, 7));
                wr_hi = 1'($urandom_range(0, 1)); wr_data = d;
            end
            rd_en  = 1'($urandom_range(0, 1));
            rd_idx = 5'($urandom_range(0, 5));
            rd_hi  = 1'($urandom_range(0, 1));
            tick();
            n_cmp++;
            if (rd_valid !== m_rv || rd_data !== m_rd || ovf_flag !== m_flag || irq !== m_irq) begin
                n_fail++;
                $display("FAIL rand_c%0d got v=%b d=%h f=%b irq=%b want v=%b d=%h f=%b irq=%b",
                         c, rd_valid, rd_data, ovf_flag, irq, m_rv, m_rd, m_flag, m_irq);
            end
        end
        idle();
        for (int i = 0; i < N; i++) begin
            for (int h = 0; h < 2; h++) begin
                rd(i, h[0]);
                n_cmp++;
                if (rd_data !== m_rd) begin
                    n_fail++; $display("FAIL rand_final%0d_%0d got %h want %h", i, h, rd_data, m_rd);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ovf_irq_en = '0;
        idle();
        test_reset();
        test_overflow_irq();
        test_write_read();
        test_write_wins();
        test_inhibit();
        test_ovf_clr_race();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_hpm_counter_bank.md
RISCV_HPM_COUNTER_BANK -- requirements
Module: riscv_hpm_counter_bank

Interface
REQ-001 Parameter NUM_COUNTERS, default 4: number of independent counters, 1..32.
REQ-002 Parameter COUNTER_WIDTH, default 64: counter width, 32 or 64 only.
REQ-003 Parameter STEP_WIDTH, default 2: width of the per-cycle increment amount.
REQ-004 Port clk, input, 1: clock, all state on rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port inc_valid, input, NUM_COUNTERS: per-counter event strobe.
REQ-007 Port inc_amount, input, NUM_COUNTERS x STEP_WIDTH: per-counter increment value, zero-extended.
REQ-008 Port inhibit, input, NUM_COUNTERS: per-counter count freeze (mcountinhibit semantics).
REQ-009 Port wr_en / wr_idx / wr_hi / wr_data, input, 1 / 5 / 1 / 32: CSR write strobe, counter index, upper-half select, data.
REQ-010 Port rd_en / rd_idx / rd_hi, input, 1 / 5 / 1: CSR read request, index, upper-half select.
REQ-011 Port rd_valid / rd_data, output, 1 / 32: registered read response.
REQ-012 Port ovf_irq_en / ovf_clr, input, NUM_COUNTERS each: overflow interrupt enable, write-1-to-clear of sticky overflow.
REQ-013 Port ovf_flag / irq, output, NUM_COUNTERS / 1: sticky overflow flags, level interrupt.

Function
REQ-014 Counter i SHALL add inc_amount[i] when inc_valid[i]=1 and inhibit[i]=0, else hold.
REQ-015 Addition SHALL wrap modulo 2^COUNTER_WIDTH; carry-out SHALL set ovf_flag[i] on the same edge.
REQ-016 inc_valid[i]=1 with inc_amount[i]=0 SHALL change neither counter nor flag.
REQ-017 Write with wr_hi=0 SHALL replace bits [31:0], keep upper bits; wr_hi=1 SHALL replace bits [63:32], keep lower bits.
REQ-018 Write to counter i and increment of counter i in the same cycle: write SHALL win, increment dropped, no overflow set.
REQ-019 Write SHALL take effect regardless of inhibit[i].
REQ-020 rd_valid SHALL assert exactly one cycle after rd_en, rd_data holding the selected half as sampled at the rd_en edge (pre-update value).
REQ-021 rd_data SHALL hold its value while rd_valid=0.
REQ-022 wr_idx or rd_idx >= NUM_COUNTERS: write ignored; read returns rd_valid=1, rd_data=0.
REQ-023 COUNTER_WIDTH=32: wr_hi=1 writes ignored, rd_hi=1 reads return 0.
REQ-024 ovf_clr[i]=1 SHALL clear ovf_flag[i]; simultaneous overflow set SHALL win over clear.
REQ-025 irq SHALL be registered: irq = OR over i of (ovf_flag[i] AND ovf_irq_en[i]), one cycle after flag change.

Reset
REQ-026 reset_n low SHALL asynchronously clear all counters, ovf_flag, rd_valid, rd_data and irq to 0.
REQ-027 Reset asserted mid-operation SHALL discard any pending read response; first post-reset cycle behaves as idle.

Structure
REQ-028 Package riscv_hpm_pkg SHALL hold default NUM_COUNTERS/COUNTER_WIDTH/STEP_WIDTH constants and the 5-bit counter index typedef.
REQ-029 Sub-module riscv_hpm_counter_slice SHALL implement one counter (write merge, increment, carry-out), instantiated NUM_COUNTERS times via generate.
REQ-030 Read mux and irq reduction SHALL live in the top module.

Verification
REQ-031 Counter 0 preset 0xFFFF_FFFF_FFFF_FFFE, inc_amount=3 once -> count 0x1, ovf_flag[0]=1, irq=1 next cycle if ovf_irq_en[0]=1.
REQ-032 Write lo 0xDEAD_BEEF then hi 0x0000_0001 to counter 2 -> read lo 0xDEADBEEF, read hi 0x00000001, each rd_valid one cycle after rd_en.
REQ-033 Write counter 1 =5 while inc_valid[1]=1, inc_amount=2 same cycle -> counter 1 reads 5.
REQ-034 inhibit[3]=1, inc_valid[3]=1 for 10 cycles -> counter 3 unchanged; release, 4 increments of 1 -> +4.
REQ-035 Overflow on counter 0 in same cycle as ovf_clr[0]=1 -> ovf_flag[0] stays 1; ovf_clr next cycle -> 0, irq drops one cycle later.
REQ-036 reset_n pulsed low between rd_en and rd_valid, rd_idx=7 with NUM_COUNTERS=4 before it -> no rd_valid after reset; separate out-of-range read returns 0.
